sort_cmp_swap: RTL and testbench

SORT_CMP_SWAP -- requirements
Module: sort_cmp_swap

---
 rtl/sort_pkg.sv | 20 ++
 rtl/sort_cmp_core.sv | 46 ++++
 rtl/sort_cmp_swap.sv | 98 +++++++++
 tb/tb_sort_cmp_swap.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sort_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sort_pkg : compare-mode encodings shared by the compare/swap block |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package sort_pkg;

    localparam int MODE_W = 3;

    typedef enum logic [MODE_W-1:0] {
        MODE_GT = 3'd0,
        MODE_LT = 3'd1,
        MODE_EQ = 3'd2,
        MODE_NE = 3'd3,
        MODE_GE = 3'd4,
        MODE_LE = 3'd5
    } mode_e;

endpackage
`default_nettype wire

// File: rtl/sort_cmp_core.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sort_cmp_core : combinational compare flag and a<b ordering bit    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module sort_cmp_core
    import sort_pkg::*;
#(
    parameter int DATAWIDTH = 32,
    parameter int SIGNED    = 0
) (
    input  logic [DATAWIDTH-1:0] a,
    input  logic [DATAWIDTH-1:0] b,
    input  logic [MODE_W-1:0]    mode,
    output logic                 flag,
    output logic                 a_lt_b
);

    logic eq;

    assign eq = (a == b);

    generate
        if (SIGNED != 0) begin : g_signed
            assign a_lt_b = ($signed(a) < $signed(b));
        end else begin : g_unsigned
            assign a_lt_b = (a < b);
        end
    endgenerate

    // GT is derived from the other two relations so only one magnitude compare exists
    always_comb begin
        flag = 1'b0;
        case (mode)
            MODE_GT: flag = !a_lt_b && !eq;
            MODE_LT: flag = a_lt_b;
            MODE_EQ: flag = eq;
            MODE_NE: flag = !eq;
            MODE_GE: flag = !a_lt_b;
            MODE_LE: flag = a_lt_b || eq;
            default: flag = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/sort_cmp_swap.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sort_cmp_swap : 2-stage elastic compare + min/max swap with counter |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module sort_cmp_swap
    import sort_pkg::*;
#(
    parameter int DATAWIDTH = 32,
    parameter int SIGNED    = 0,
    parameter int CNTWIDTH  = 16
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATAWIDTH-1:0] a,
    input  logic [DATAWIDTH-1:0] b,
    input  logic [MODE_W-1:0]    mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 c,
    output logic [DATAWIDTH-1:0] lo,
    output logic [DATAWIDTH-1:0] hi,
    output logic [CNTWIDTH-1:0]  cnt
);

    logic                 cmp_flag;
    logic                 cmp_lt;

    logic                 s1_valid;
    logic                 s1_flag;
    logic                 s1_lt;
    logic [DATAWIDTH-1:0] s1_a;
    logic [DATAWIDTH-1:0] s1_b;
    logic                 s2_valid;

    logic                 s1_en;
    logic                 s2_en;
    logic                 out_fire;

    sort_cmp_core #(
        .DATAWIDTH (DATAWIDTH),
        .SIGNED    (SIGNED)
    ) u_core (
        .a      (a),
        .b      (b),
        .mode   (mode),
        .flag   (cmp_flag),
        .a_lt_b (cmp_lt)
    );

    // Ready chain is built only from stage state and out_ready, never in_valid
    assign s2_en     = !s2_valid || out_ready;
    assign s1_en     = !s1_valid || s2_en;
    assign in_ready  = !Rst && s1_en;
    assign out_valid = !Rst && s2_valid;
    assign out_fire  = out_valid && out_ready;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            s1_valid <= 1'b0;
            s1_flag  <= 1'b0;
            s1_lt    <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s2_valid <= 1'b0;
            c        <= 1'b0;
            lo       <= '0;
            hi       <= '0;
            cnt      <= '0;
        end else begin
            if (s1_en) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_flag <= cmp_flag;
                    s1_lt   <= cmp_lt;
                    s1_a    <= a;
                    s1_b    <= b;
                end
            end
            // Equal operands take the !lt path, giving lo=b=a and hi=a=b
            if (s2_en) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    c  <= s1_flag;
                    lo <= s1_lt ? s1_a : s1_b;
                    hi <= s1_lt ? s1_b : s1_a;
                end
            end
            if (out_fire && (cnt != {CNTWIDTH{1'b1}})) begin
                cnt <= cnt + CNTWIDTH'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sort_cmp_swap.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_sort_cmp_swap : scoreboard bench, unsigned and signed instances |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_sort_cmp_swap;

    typedef struct packed {
        logic        c;
        logic [31:0] lo;
        logic [31:0] hi;
    } res_t;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] a_i = '0;
    logic [31:0] b_i = '0;
    logic [2:0]  mode_i = '0;

    logic        in_ready_u, in_ready_s, out_valid_u, out_valid_s, c_u, c_s;
    logic [31:0] lo_u, hi_u, lo_s, hi_s;
    logic [3:0]  cnt_u, cnt_s;

    int   checks = 0;
    int   failures = 0;
    int   exp_cnt = 0;
    bit   rand_ready = 1'b0;
    bit   hold_prev = 1'b0;
    logic [129:0] prev_out = '0;
    res_t q_u[$];
    res_t q_s[$];

    always #5 Clk = ~Clk;

    sort_cmp_swap #(.DATAWIDTH(32), .SIGNED(0), .CNTWIDTH(4)) dut_u (
        .Clk(Clk), .Rst(Rst), .in_valid(in_valid), .in_ready(in_ready_u),
        .a(a_i), .b(b_i), .mode(mode_i), .out_valid(out_valid_u),
        .out_ready(out_ready), .c(c_u), .lo(lo_u), .hi(hi_u), .cnt(cnt_u)
    );

    sort_cmp_swap #(.DATAWIDTH(32), .SIGNED(1), .CNTWIDTH(4)) dut_s (
        .Clk(Clk), .Rst(Rst), .in_valid(in_valid), .in_ready(in_ready_s),
        .a(a_i), .b(b_i), .mode(mode_i), .out_valid(out_valid_s),
        .out_ready(out_ready), .c(c_s), .lo(lo_s), .hi(hi_s), .cnt(cnt_s)
    );

    // Reference: operands as plain integers; lo/hi are min/max, ties keep lo=a
    function automatic res_t model(input logic [31:0] x, input logic [31:0] y,
                                   input logic [2:0] m, input bit sgn);
        longint sx, sy;
        res_t   r;
        sx = sgn ? longint'($signed(x)) : longint'(x);
        sy = sgn ? longint'($signed(y)) : longint'(y);
        case (m)
            3'd0:    r.c = (sx >  sy);
            3'd1:    r.c = (sx <  sy);
            3'd2:    r.c = (sx == sy);
            3'd3:    r.c = (sx != sy);
            3'd4:    r.c = (sx >= sy);
            3'd5:    r.c = (sx <= sy);
            default: r.c = 1'b0;
        endcase
        r.lo = (sx <= sy) ? x : y;
        r.hi = (sx <= sy) ? y : x;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic pop_cmp(input string nm, inout res_t q[$], input logic cc,
                           input logic [31:0] l, input logic [31:0] h, input logic [3:0] cn);
        res_t e;
        if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s_spurious actual=out_valid required=no_pending_result", nm);
        end else begin
            e = q.pop_front();
            chk({nm, "_res"}, {31'b0, cc, l, h}, {31'b0, e.c, e.lo, e.hi});
            chk({nm, "_cnt"}, 64'(cn), 64'(exp_cnt));
        end
    endtask

    // Input monitor: predict both instances on every accepted input
    always @(negedge Clk) begin
        if (!Rst && in_valid && in_ready_u) begin
            q_u.push_back(model(a_i, b_i, mode_i, 1'b0));
            q_s.push_back(model(a_i, b_i, mode_i, 1'b1));
        end
    end

    // Output monitor
    always @(negedge Clk) begin
        if (Rst) begin
            chk("rst_out_valid", {62'b0, out_valid_u, out_valid_s}, 64'd0);
            q_u.delete();
            q_s.delete();
            exp_cnt   = 0;
            hold_prev = 1'b0;
        end else begin
            if (hold_prev)
                chk("hold_stable", 64'(prev_out[129:66]) ^ 64'(prev_out[65:2]),
                    64'({c_u, lo_u, hi_u, c_s, lo_s, hi_s} >> 66) ^
                    64'({c_u, lo_u, hi_u, c_s, lo_s, hi_s} >> 2));
            if (hold_prev)
                chk("hold_stable_lo", 64'(prev_out[63:0]), 64'({c_u, lo_u, hi_u, c_s, lo_s, hi_s}));
            if (out_valid_u && out_ready) pop_cmp("u", q_u, c_u, lo_u, hi_u, cnt_u);
            if (out_valid_s && out_ready) pop_cmp("s", q_s, c_s, lo_s, hi_s, cnt_s);
            if (out_valid_u && out_ready && exp_cnt < 15) exp_cnt++;
            hold_prev = out_valid_u && !out_ready;
            prev_out  = {c_u, lo_u, hi_u, c_s, lo_s, hi_s};
        end
    end

    initial begin
        forever begin
            @(posedge Clk);
            #1;
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic send(input logic [31:0] x, input logic [31:0] y, input logic [2:0] m);
        int n;
        bit acc;
        a_i = x; b_i = y; mode_i = m; in_valid = 1'b1;
        n = 0;
        forever begin
            @(negedge Clk);
            acc = in_ready_u;
            @(posedge Clk);
            #1;
            if (acc) break;
            n++;
            if (n > 200) begin
                checks++;
                failures++;
                $display("FAIL send_timeout actual=no_accept required=accept");
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        n = 0;
        while ((q_u.size() != 0 || q_s.size() != 0) && n < 500) begin
            @(posedge Clk);
            #1;
            n++;
        end
        chk("drain_empty", 64'(q_u.size() + q_s.size()), 64'd0);
    endtask

    initial begin
        logic [31:0] x, y;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        chk("rst_in_ready", {62'b0, in_ready_u, in_ready_s}, 64'd0);
        @(posedge Clk);
        #1;
        Rst = 1'b0;
        @(negedge Clk);
        chk("post_rst_in_ready", {62'b0, in_ready_u, in_ready_s}, 64'd3);
        chk("post_rst_outs", {c_u, lo_u, hi_u[27:0], cnt_u}, 64'd0);
        @(posedge Clk);
        #1;

        // Latency and first result
        send(32'd5, 32'd3, 3'd0);
        @(negedge Clk);
        chk("lat_not_yet", 64'(out_valid_u), 64'd0);
        @(negedge Clk);
        chk("lat_valid", 64'(out_valid_u), 64'd1);
        chk("gt_5_3", {31'b0, c_u, lo_u, hi_u}, {31'b0, 1'b1, 32'd3, 32'd5});
        @(negedge Clk);
        chk("cnt_one", 64'(cnt_u), 64'd1);
        @(posedge Clk);
        #1;

        // Signedness boundary and tie behaviour across every mode
        send(32'hFFFF_FFFF, 32'd1, 3'd1);
        for (int m = 0; m < 8; m++) send(32'd7, 32'd7, 3'(m));
        drain();

        // Backpressure: two held, third refused until release
        out_ready = 1'b0;
        send(32'd10, 32'd20, 3'd1);
        send(32'd40, 32'd30, 3'd0);
        a_i = 32'd50; b_i = 32'd60; mode_i = 3'd3; in_valid = 1'b1;
        @(negedge Clk);
        chk("full_in_ready", {62'b0, in_ready_u, in_ready_s}, 64'd0);
        @(posedge Clk);
        #1;
        @(negedge Clk);
        chk("full_in_ready2", {62'b0, in_ready_u, in_ready_s}, 64'd0);
        chk("full_out_valid", 64'(out_valid_u), 64'd1);
        @(posedge Clk);
        #1;
        out_ready = 1'b1;
        send(32'd50, 32'd60, 3'd3);
        drain();

        // Reset with two results in flight
        out_ready = 1'b0;
        send(32'd1, 32'd2, 3'd1);
        send(32'd3, 32'd4, 3'd1);
        Rst = 1'b1;
        @(negedge Clk);
        chk("rst_mid_in_ready", 64'(in_ready_u), 64'd0);
        @(posedge Clk);
        #1;
        Rst = 1'b0;
        out_ready = 1'b1;
        @(negedge Clk);
        chk("rst_mid_out_valid", {62'b0, out_valid_u, out_valid_s}, 64'd0);
        chk("rst_mid_cnt", {56'b0, cnt_u, cnt_s}, 64'd0);
        chk("rst_mid_in_ready_after", 64'(in_ready_u), 64'd1);
        @(posedge Clk);
        #1;

        // Counter saturation
        for (int i = 0; i < 20; i++) send(32'(i), 32'(19 - i), 3'(i % 8));
        drain();
        @(negedge Clk);
        chk("cnt_sat", {56'b0, cnt_u, cnt_s}, {56'b0, 4'hF, 4'hF});
        @(posedge Clk);
        #1;

        // Randomized traffic with random downstream stalls
        rand_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            x = $urandom;
            case ($urandom_range(0, 3))
                0:       y = x;
                1:       y = $urandom;
                2: begin
                    x = $urandom_range(0, 1) ? 32'h8000_0000 : 32'h7FFF_FFFF;
                    y = $urandom_range(0, 1) ? 32'hFFFF_FFFF : 32'h0000_0000;
                end
                default: begin
                    x = 32'($urandom_range(0, 3));
                    y = 32'($urandom_range(0, 3));
                end
            endcase
            send(x, y, 3'($urandom_range(0, 7)));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge Clk);
                #1;
            end
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
